// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - pipelined instruction fetch with fetch queue, redirect flush and halt detect
module if_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]     HALT_INST = 32'h0000_000C
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            jump,
    input  logic            jump_register,
    input  logic            branch,
    input  logic            zero,
    input  logic [25:0]     jea,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] imm_extend,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            halted
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DEPTH_W = DEPTH[CW:0];
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [31:0]     q_inst [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   drop_cnt;
    logic            halted_q;

    logic            redirect_raw;
    logic            redirect;
    logic [XLEN-1:0] ex_pc_plus4;
    logic [XLEN-1:0] target;
    logic [CW:0]     in_flight;
    logic            accept;
    logic            resp_take;
    logic            deq;
    logic            halt_hit;

    // Redirects come from an older instruction, so they are dead once halted
    assign redirect_raw = jump_register || jump || (branch && zero);
    assign redirect     = redirect_raw && !halted_q;
    assign ex_pc_plus4  = ex_pc + PC_STEP;

    always_comb begin
        target = ex_pc_plus4 + (imm_extend << 2);
        if (jump_register) begin
            target = rs_data;
        end else if (jump) begin
            target = {ex_pc_plus4[XLEN-1:28], jea, 2'b00};
        end
    end

    // Queue slots plus in-flight requests bound the queue occupancy
    assign in_flight = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = !rst && !halted_q && !redirect && (in_flight < DEPTH_W);
    assign imem_addr = fetch_pc;

    assign accept    = imem_req && imem_ready;
    assign resp_take = imem_rvalid && (drop_cnt == '0) && !halted_q;
    assign inst_valid = !halted_q && (count != '0);
    assign deq       = inst_valid && inst_ready;
    assign halt_hit  = deq && (inst == HALT_INST);

    assign inst    = (count != '0) ? q_inst[head] : 32'h0;
    assign inst_pc = (count != '0) ? q_pc[head]   : '0;
    assign halted  = halted_q;

    always_comb begin
        outstanding_next = outstanding;
        case ({accept, imem_rvalid})
            2'b10:   outstanding_next = outstanding + CW'(1);
            2'b01:   outstanding_next = outstanding - CW'(1);
            default: outstanding_next = outstanding;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resp_take) begin
            q_inst[tail] <= imem_rdata;
            q_pc[tail]   <= resp_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            halted_q    <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            if (imem_rvalid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (accept) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (resp_take) begin
                resp_pc <= resp_pc + PC_STEP;
                tail    <= tail + AW'(1);
            end
            if (deq) begin
                head <= head + AW'(1);
            end
            case ({resp_take, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (halt_hit && !redirect) begin
                halted_q <= 1'b1;
            end
            // Everything still in flight after this edge is wrong-path
            if (redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                drop_cnt <= outstanding_next;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed bench for if_fetch_unit with a queue-based reference model
module tb_if_fetch_unit;

    localparam int          XLEN      = 32;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] HALT_INST = 32'h0000_000C;
    localparam logic [31:0] NO_HALT   = 32'hFFFF_FFF0;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ex_pc;
    logic        jump;
    logic        jump_register;
    logic        branch;
    logic        zero;
    logic [25:0] jea;
    logic [31:0] rs_data;
    logic [31:0] imm_extend;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;

    if_fetch_unit #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .HALT_INST(HALT_INST)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ex_pc(ex_pc), .jump(jump), .jump_register(jump_register),
        .branch(branch), .zero(zero), .jea(jea), .rs_data(rs_data),
        .imm_extend(imm_extend),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [31:0] halt_pc = NO_HALT;
    int          lat = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == halt_pc) ? HALT_INST : {8'hA5, a[23:0]};
    endfunction

    // Instruction memory: in-order responses, fixed latency in cycles
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend[$];
    int    icyc = 0;

    initial begin
        pend_t p;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
            end else if (imem_req && imem_ready) begin
                p.addr = imem_addr;
                p.due  = icyc + lat;
                pend.push_back(p);
            end
            @(posedge clk);
            #2;
            icyc++;
            if (!rst && pend.size() > 0 && pend[0].due <= icyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rvalid = 1'b0;
            end
        end
    end

    // Reference model: fetch queue as a plain queue of {inst, pc}
    typedef struct packed { logic [31:0] w; logic [31:0] pc; } entry_t;
    entry_t      mq[$];
    logic [31:0] m_fetch, m_resp;
    int          m_out, m_drop;
    bit          m_halted;
    int          cyc_n;
    logic [31:0] acc_log[$];
    logic [31:0] deq_log[$];
    int          acc_cyc[$];
    int          deq_cyc[$];

    initial begin
        bit          redir, e_req, e_valid, acc, dq;
        logic [31:0] tgt, pc4, head_w;
        entry_t      e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
                m_fetch = RESET_PC; m_resp = RESET_PC;
                m_out = 0; m_drop = 0; m_halted = 0; cyc_n = -1;
                check("rst_imem_req", imem_req, 0);
                check("rst_imem_addr", imem_addr, RESET_PC);
                check("rst_inst_valid", inst_valid, 0);
                check("rst_inst", inst, 0);
                check("rst_inst_pc", inst_pc, 0);
                check("rst_halted", halted, 0);
                continue;
            end
            cyc_n++;
            redir = !m_halted && (jump_register || jump || (branch && zero));
            pc4 = ex_pc + 32'd4;
            if (jump_register)  tgt = rs_data;
            else if (jump)      tgt = {pc4[31:28], jea, 2'b00};
            else                tgt = pc4 + (imm_extend * 4);
            e_req   = !m_halted && !redir && (mq.size() + m_out < DEPTH);
            e_valid = !m_halted && mq.size() > 0;
            check("imem_req", imem_req, e_req);
            check("imem_addr", imem_addr, m_fetch);
            check("inst_valid", inst_valid, e_valid);
            check("halted", halted, m_halted);
            if (e_valid) begin
                check("inst", inst, mq[0].w);
                check("inst_pc", inst_pc, mq[0].pc);
            end
            acc = e_req && imem_ready;
            dq  = e_valid && inst_ready;
            head_w = e_valid ? mq[0].w : 32'h0;
            if (dq) begin
                deq_log.push_back(mq[0].pc);
                deq_cyc.push_back(cyc_n);
                void'(mq.pop_front());
            end
            if (imem_rvalid) begin
                m_out--;
                if (m_drop > 0) begin
                    m_drop--;
                end else if (!m_halted) begin
                    e.w = imem_rdata; e.pc = m_resp;
                    mq.push_back(e);
                    m_resp += 4;
                end
            end
            if (acc) begin
                acc_log.push_back(m_fetch);
                acc_cyc.push_back(cyc_n);
                m_fetch += 4;
                m_out++;
            end
            if (dq && head_w == HALT_INST && !redir) m_halted = 1;
            if (redir) begin
                m_fetch = tgt; m_resp = tgt;
                mq.delete();
                m_drop = m_out;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        jump = 0; jump_register = 0; branch = 0; zero = 0;
        ex_pc = '0; jea = '0; rs_data = '0; imm_extend = '0;
    endtask

    task automatic do_reset(input int lat_v, input logic [31:0] halt_v);
        rst = 1'b1;
        clear_ex();
        imem_ready = 1'b1;
        inst_ready = 1'b1;
        lat = lat_v;
        halt_pc = halt_v;
        acc_log.delete(); deq_log.delete(); acc_cyc.delete(); deq_cyc.delete();
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        do_reset(1, NO_HALT);

        // Streaming from reset with 1-cycle memory
        step(8);
        check("s1_acc_size", acc_log.size() >= 3, 1);
        check("s1_acc0", acc_log[0], 32'h0);
        check("s1_acc1", acc_log[1], 32'h4);
        check("s1_acc2", acc_log[2], 32'h8);
        check("s1_deq0", deq_log[0], 32'h0);
        check("s1_deq1", deq_log[1], 32'h4);
        check("s1_deq2", deq_log[2], 32'h8);
        check("s1_first_latency", deq_cyc[0] - acc_cyc[0], 2);
        check("s1_consecutive", deq_cyc[2] - deq_cyc[0], 2);

        // ID stall fills the queue exactly
        do_reset(1, NO_HALT);
        inst_ready = 1'b0;
        step(10);
        check("s2_acc_count", acc_log.size(), 4);
        check("s2_req_low", imem_req, 0);
        check("s2_valid", inst_valid, 1);
        check("s2_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        step(6);
        check("s2_deq0", deq_log[0], 32'h0);
        check("s2_deq1", deq_log[1], 32'h4);
        check("s2_deq2", deq_log[2], 32'h8);
        check("s2_deq3", deq_log[3], 32'hC);
        check("s2_deq4", deq_log[4], 32'h10);

        // Taken branch with two requests outstanding
        do_reset(3, NO_HALT);
        step(2);
        branch = 1; zero = 1; ex_pc = 32'h10; imm_extend = 32'hFFFF_FFFE;
        step(1);
        clear_ex();
        check("s3_acc_before", acc_log.size(), 2);
        step(12);
        check("s3_acc_target", acc_log[2], 32'hC);
        check("s3_deq0", deq_log[0], 32'hC);
        check("s3_deq1", deq_log[1], 32'h10);
        check("s3_deq0_cycle", deq_cyc[0], 7);

        // jump and jump_register together: register target wins
        do_reset(1, NO_HALT);
        step(3);
        jump = 1; jea = 26'h40; ex_pc = 32'h1000_0000;
        jump_register = 1; rs_data = 32'h200;
        step(1);
        clear_ex();
        acc_log.delete(); deq_log.delete();
        step(6);
        check("s4_jr_acc", acc_log[0], 32'h200);
        check("s4_jr_deq0", deq_log[0], 32'h200);
        check("s4_jr_deq1", deq_log[1], 32'h204);
        jump = 1; jea = 26'h40; ex_pc = 32'h1000_0000;
        step(1);
        clear_ex();
        acc_log.delete(); deq_log.delete();
        step(6);
        check("s4_j_acc", acc_log[0], 32'h1000_0100);
        check("s4_j_deq0", deq_log[0], 32'h1000_0100);

        // Halt at pc 0x14, later jump ignored
        do_reset(1, 32'h14);
        step(7);
        check("s5_head_is_halt", {inst_valid, inst_pc}, {1'b1, 32'h14});
        step(1);
        check("s5_halted", halted, 1);
        jump = 1; jea = 26'h80; ex_pc = 32'h40;
        step(1);
        clear_ex();
        acc_log.delete();
        step(8);
        check("s5_still_halted", halted, 1);
        check("s5_req_low", imem_req, 0);
        check("s5_valid_low", inst_valid, 0);
        check("s5_no_fetch", acc_log.size(), 0);
        check("s5_deq_count", deq_log.size(), 6);
        check("s5_last_deq", deq_log[5], 32'h14);

        // Halt word dequeued together with a taken branch
        do_reset(1, 32'h14);
        step(7);
        check("s6_head_is_halt", {inst_valid, inst_pc}, {1'b1, 32'h14});
        branch = 1; zero = 1; ex_pc = 32'h100; imm_extend = 32'h0;
        step(1);
        clear_ex();
        deq_log.delete();
        step(8);
        check("s6_not_halted", halted, 0);
        check("s6_deq0", deq_log[0], 32'h104);

        // Irregular memory acceptance and ID back-pressure
        do_reset(2, NO_HALT);
        for (int i = 0; i < 40; i++) begin
            imem_ready = (i % 3) != 0;
            inst_ready = (i % 4) != 1;
            if (i == 20) begin
                branch = 1; zero = 1; ex_pc = 32'h30; imm_extend = 32'h4;
            end else begin
                clear_ex();
            end
            step(1);
        end
        clear_ex();
        imem_ready = 1'b1;
        inst_ready = 1'b1;
        step(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
